// File: rtl/conv_block_sequencer.sv
// conv_block_sequencer: frame-level controller stepping the line-buffer address FSM through LOAD, PROCESS and DRAIN for each column block.
// Optional watchdog: define CONV_SEQ_WATCHDOG_EN to abort stalled frames after NB_TIMEOUT-bit all-ones wait cycles.
// Ports:
//   i_CLK, i_reset          clock, synchronous active-high reset
//   i_start                 frame start request (accepted in IDLE only)
//   i_imgLength             words per block, latched on accepted start
//   i_numBlocks             blocks per frame, latched on accepted start
//   i_hostValid             host word strobe, counted on its rising edge
//   i_changeBlock, i_EoP    block-finished / process-finished flags from the address FSM
//   o_load, o_SoP           load and start-of-process controls to the address FSM
//   o_phase                 0=IDLE 1=LOAD 2=PROC 3=DRAIN
//   o_blockIdx              0-based index of the current block
//   o_busy, o_done, o_error not-IDLE flag, end-of-frame pulse, sticky fault flag
module conv_block_sequencer #(
    parameter int NB_IMAGE   = 10,
    parameter int NB_BLOCK   = 8,
    parameter int NB_TIMEOUT = 16
) (
    input  logic                i_CLK,
    input  logic                i_reset,
    input  logic                i_start,
    input  logic [NB_IMAGE-1:0] i_imgLength,
    input  logic [NB_BLOCK-1:0] i_numBlocks,
    input  logic                i_hostValid,
    input  logic                i_changeBlock,
    input  logic                i_EoP,
    output logic                o_load,
    output logic                o_SoP,
    output logic [1:0]          o_phase,
    output logic [NB_BLOCK-1:0] o_blockIdx,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_error
);
    typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, PROC = 2'd2, DRAIN = 2'd3} state_t;
    state_t              state;
    logic [NB_IMAGE-1:0] imgLength;
    logic [NB_IMAGE-1:0] wordCnt;
    logic [NB_BLOCK-1:0] numBlocks;
    logic                hostValidPrev;
    logic                changeBlockPrev;
    logic                hostRise;
    logic                blockRise;
    logic                loadDone;
    logic                procDone;
    logic                drainDone;
    always_comb begin
        hostRise  = i_hostValid && !hostValidPrev;
        blockRise = i_changeBlock && !changeBlockPrev;
        // a changeBlock rise only ends LOAD once all words are in and o_load has dropped
        loadDone  = (state == LOAD) && !o_load && blockRise;
        procDone  = (state == PROC) && i_EoP;
        drainDone = (state == DRAIN) && blockRise;
    end
    assign o_phase = state;
`ifdef CONV_SEQ_WATCHDOG_EN
    logic [NB_TIMEOUT-1:0] wdCnt;
`else
    logic unusedTimeoutWidth;
    assign unusedTimeoutWidth = (NB_TIMEOUT > 0);
`endif
    always_ff @(posedge i_CLK) begin
        if (i_reset) begin
            state           <= IDLE;
            imgLength       <= '0;
            numBlocks       <= '0;
            wordCnt         <= '0;
            hostValidPrev   <= 1'b0;
            changeBlockPrev <= 1'b0;
            o_load          <= 1'b0;
            o_SoP           <= 1'b0;
            o_blockIdx      <= '0;
            o_busy          <= 1'b0;
            o_done          <= 1'b0;
            o_error         <= 1'b0;
`ifdef CONV_SEQ_WATCHDOG_EN
            wdCnt           <= '0;
`endif
        end else begin
            hostValidPrev   <= i_hostValid;
            changeBlockPrev <= i_changeBlock;
            o_SoP           <= 1'b0;
            o_done          <= 1'b0;
            // a start request during a frame is a protocol violation; the frame carries on
            if (i_start && o_busy)
                o_error <= 1'b1;
            case (state)
                IDLE: if (i_start && i_numBlocks != '0 && i_imgLength != '0) begin
                    imgLength  <= i_imgLength;
                    numBlocks  <= i_numBlocks;
                    wordCnt    <= '0;
                    o_blockIdx <= '0;
                    o_load     <= 1'b1;
                    o_busy     <= 1'b1;
                    state      <= LOAD;
                end
                LOAD: begin
                    // counter saturates at imgLength; o_load drops the edge after it gets there
                    if (wordCnt == imgLength)
                        o_load <= 1'b0;
                    else if (hostRise)
                        wordCnt <= wordCnt + 1'b1;
                    if (loadDone) begin
                        o_SoP <= 1'b1;
                        state <= PROC;
                    end
                end
                PROC: if (procDone) begin
                    wordCnt <= '0;
                    state   <= DRAIN;
                end
                DRAIN: if (drainDone) begin
                    if (o_blockIdx == numBlocks - 1'b1) begin
                        o_done <= 1'b1;
                        o_busy <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        o_blockIdx <= o_blockIdx + 1'b1;
                        o_load     <= 1'b1;
                        state      <= LOAD;
                    end
                end
            endcase
`ifdef CONV_SEQ_WATCHDOG_EN
            // only waiting phases age the watchdog; any transition restarts it
            if (state == IDLE || (state == LOAD && o_load) || loadDone || procDone || drainDone)
                wdCnt <= '0;
            else if (wdCnt == '1) begin
                wdCnt   <= '0;
                o_error <= 1'b1;
                o_load  <= 1'b0;
                o_SoP   <= 1'b0;
                o_busy  <= 1'b0;
                state   <= IDLE;
            end else
                wdCnt <= wdCnt + 1'b1;
`endif
        end
    end
endmodule

// File: tb/tb_conv_block_sequencer.sv
// tb_conv_block_sequencer: directed vector table, corner sequences and randomized frames checked against frame-level expectations.
module tb_conv_block_sequencer;
    localparam int NB_IMAGE   = 10;
    localparam int NB_BLOCK   = 8;
    localparam int NB_TIMEOUT = 16;
    logic                i_CLK = 1'b0;
    logic                i_reset = 1'b1;
    logic                i_start = 1'b0;
    logic [NB_IMAGE-1:0] i_imgLength = '0;
    logic [NB_BLOCK-1:0] i_numBlocks = '0;
    logic                i_hostValid = 1'b0;
    logic                i_changeBlock = 1'b0;
    logic                i_EoP = 1'b0;
    logic                o_load;
    logic                o_SoP;
    logic [1:0]          o_phase;
    logic [NB_BLOCK-1:0] o_blockIdx;
    logic                o_busy;
    logic                o_done;
    logic                o_error;
    int                  nCmp = 0;
    int                  nFail = 0;
    int                  doneCnt = 0;
    int                  sopCnt = 0;
    int                  loadEntries = 0;
    logic [1:0]          prevPhase = 2'd0;
    bit                  expErr = 1'b0;

    conv_block_sequencer #(
        .NB_IMAGE(NB_IMAGE), .NB_BLOCK(NB_BLOCK), .NB_TIMEOUT(NB_TIMEOUT)
    ) dut (
        .i_CLK(i_CLK), .i_reset(i_reset), .i_start(i_start),
        .i_imgLength(i_imgLength), .i_numBlocks(i_numBlocks),
        .i_hostValid(i_hostValid), .i_changeBlock(i_changeBlock), .i_EoP(i_EoP),
        .o_load(o_load), .o_SoP(o_SoP), .o_phase(o_phase), .o_blockIdx(o_blockIdx),
        .o_busy(o_busy), .o_done(o_done), .o_error(o_error)
    );

    always #5 i_CLK = ~i_CLK;

    // frame-level event counters: done pulses, SoP cycles and entries into LOAD
    always @(negedge i_CLK) begin
        if (o_done) doneCnt++;
        if (o_SoP) sopCnt++;
        if (o_phase == 2'd1 && prevPhase != 2'd1) loadEntries++;
        prevPhase = o_phase;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    typedef struct {
        bit start; bit hv; bit cb; bit eop;
        bit load; bit sop; int phase; bit busy; bit done;
    } vec_t;
    vec_t vecs[15];

    task automatic step();
        @(posedge i_CLK);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        nCmp++;
        if (act != exp) begin
            nFail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic checkAll(input string tag, input int load, input int sop, input int phase,
                            input int busy, input int idx, input int done);
        check({tag, ".load"}, o_load, load);
        check({tag, ".SoP"}, o_SoP, sop);
        check({tag, ".phase"}, o_phase, phase);
        check({tag, ".busy"}, o_busy, busy);
        check({tag, ".blockIdx"}, o_blockIdx, idx);
        check({tag, ".done"}, o_done, done);
        check({tag, ".error"}, o_error, expErr);
    endtask

    task automatic beginFrame(input int len, input int nb);
        i_start = 1'b1;
        i_imgLength = NB_IMAGE'(len);
        i_numBlocks = NB_BLOCK'(nb);
        step();
        i_start = 1'b0;
        check("startPhase", o_phase, 1);
        check("startLoad", o_load, 1);
        check("startBusy", o_busy, 1);
    endtask

    task automatic word(input int hold);
        i_hostValid = 1'b1;
        repeat (hold) step();
        i_hostValid = 1'b0;
        step();
    endtask

    task automatic enterProc();
        i_changeBlock = 1'b1;
        step();
        check("procEntryPhase", o_phase, 2);
        check("procEntrySoP", o_SoP, 1);
        check("procEntryLoad", o_load, 0);
        i_changeBlock = 1'b0;
        step();
        check("procSoPLow", o_SoP, 0);
        check("procPhase", o_phase, 2);
    endtask

    task automatic loadBlock(input int len, input int b, input bit noisy);
        check("loadIdx", o_blockIdx, b);
        for (int w = 0; w < len; w++) begin
            repeat ($urandom_range(0, 2)) step();
            if (noisy && w == 0) begin
                i_EoP = 1'b1;
                step();
                i_EoP = 1'b0;
                check("eopIgnoredInLoad", o_phase, 1);
            end
            word($urandom_range(1, 3));
            check("loadLevel", o_load, (w < len - 1) ? 1 : 0);
        end
        repeat ($urandom_range(0, 3)) step();
        check("loadWaitPhase", o_phase, 1);
        enterProc();
    endtask

    task automatic procDrain(input int b, input int nb, input bit noisy);
        if (noisy) begin
            i_changeBlock = 1'b1;
            step();
            i_changeBlock = 1'b0;
            step();
            check("cbIgnoredInProc", o_phase, 2);
        end
        repeat ($urandom_range(0, 3)) step();
        check("procWaitPhase", o_phase, 2);
        i_EoP = 1'b1;
        step();
        i_EoP = 1'b0;
        check("drainPhase", o_phase, 3);
        repeat ($urandom_range(0, 3)) step();
        check("drainLoad", o_load, 0);
        check("drainSoP", o_SoP, 0);
        check("drainBusy", o_busy, 1);
        i_changeBlock = 1'b1;
        step();
        if (b == nb - 1) begin
            check("lastDone", o_done, 1);
            check("lastPhase", o_phase, 0);
            check("lastBusy", o_busy, 0);
            check("lastIdx", o_blockIdx, b);
        end else begin
            check("nextDone", o_done, 0);
            check("nextPhase", o_phase, 1);
            check("nextLoad", o_load, 1);
            check("nextIdx", o_blockIdx, b + 1);
        end
        i_changeBlock = 1'b0;
        step();
        check("donePulseEnds", o_done, 0);
    endtask

    task automatic runFrame(input int len, input int nb, input bit noisy);
        int d0, s0, l0;
        d0 = doneCnt;
        s0 = sopCnt;
        l0 = loadEntries;
        beginFrame(len, nb);
        for (int b = 0; b < nb; b++) begin
            loadBlock(len, b, noisy);
            procDrain(b, nb, noisy);
        end
        check("frameDoneCount", doneCnt - d0, 1);
        check("frameSoPCount", sopCnt - s0, nb);
        check("frameLoadEntries", loadEntries - l0, nb);
        check("frameError", o_error, expErr);
    endtask

    initial begin
        int d0;
        vecs[0]  = '{1, 0, 0, 0, 1, 0, 1, 1, 0};
        vecs[1]  = '{0, 1, 0, 0, 1, 0, 1, 1, 0};
        vecs[2]  = '{0, 0, 0, 0, 1, 0, 1, 1, 0};
        vecs[3]  = '{0, 1, 0, 0, 1, 0, 1, 1, 0};
        vecs[4]  = '{0, 0, 0, 0, 1, 0, 1, 1, 0};
        vecs[5]  = '{0, 1, 0, 0, 1, 0, 1, 1, 0};
        vecs[6]  = '{0, 0, 0, 0, 1, 0, 1, 1, 0};
        vecs[7]  = '{0, 1, 0, 0, 1, 0, 1, 1, 0};
        vecs[8]  = '{0, 0, 0, 0, 0, 0, 1, 1, 0};
        vecs[9]  = '{0, 0, 1, 0, 0, 1, 2, 1, 0};
        vecs[10] = '{0, 0, 0, 0, 0, 0, 2, 1, 0};
        vecs[11] = '{0, 0, 0, 1, 0, 0, 3, 1, 0};
        vecs[12] = '{0, 0, 0, 0, 0, 0, 3, 1, 0};
        vecs[13] = '{0, 0, 1, 0, 0, 0, 0, 0, 1};
        vecs[14] = '{0, 0, 0, 0, 0, 0, 0, 0, 0};

        repeat (3) step();
        checkAll("reset", 0, 0, 0, 0, 0, 0);
        i_reset = 1'b0;
        step();

        // single block, imgLength=4, cycle by cycle
        i_imgLength = 10'd4;
        i_numBlocks = 8'd1;
        for (int i = 0; i < 15; i++) begin
            i_start = vecs[i].start;
            i_hostValid = vecs[i].hv;
            i_changeBlock = vecs[i].cb;
            i_EoP = vecs[i].eop;
            step();
            checkAll($sformatf("vec%0d", i), vecs[i].load, vecs[i].sop, vecs[i].phase,
                     vecs[i].busy, 0, vecs[i].done);
        end

        // zero-sized starts are ignored without error
        i_start = 1'b1;
        i_imgLength = 10'd4;
        i_numBlocks = 8'd0;
        step();
        checkAll("zeroBlocks", 0, 0, 0, 0, 0, 0);
        i_imgLength = 10'd0;
        i_numBlocks = 8'd2;
        step();
        checkAll("zeroLength", 0, 0, 0, 0, 0, 0);
        i_start = 1'b0;
        step();

        // held strobe counts once
        beginFrame(4, 1);
        i_hostValid = 1'b1;
        repeat (10) step();
        check("heldLoad", o_load, 1);
        check("heldPhase", o_phase, 1);
        i_hostValid = 1'b0;
        step();
        for (int w = 0; w < 3; w++) begin
            word(1);
            check("heldRestLoad", o_load, (w < 2) ? 1 : 0);
        end
        enterProc();
        procDrain(0, 1, 0);

        // last word and changeBlock rise together: count wins, a later rise is needed
        beginFrame(2, 1);
        word(1);
        i_hostValid = 1'b1;
        i_changeBlock = 1'b1;
        step();
        check("coincLoad", o_load, 1);
        check("coincPhase", o_phase, 1);
        i_hostValid = 1'b0;
        step();
        check("coincLoadFall", o_load, 0);
        check("coincStillLoad", o_phase, 1);
        i_changeBlock = 1'b0;
        step();
        check("coincWait", o_phase, 1);
        enterProc();
        procDrain(0, 1, 0);

        // three-block frame
        runFrame(3, 3, 0);

        // start while busy: error set, latched sizes untouched
        beginFrame(2, 1);
        word(1);
        i_start = 1'b1;
        i_imgLength = 10'd7;
        i_numBlocks = 8'd5;
        step();
        i_start = 1'b0;
        expErr = 1'b1;
        check("busyStartError", o_error, 1);
        check("busyStartPhase", o_phase, 1);
        check("busyStartLoad", o_load, 1);
        word(1);
        check("busyStartLenKept", o_load, 0);
        enterProc();
        procDrain(0, 1, 0);

        // randomized frames
        for (int f = 0; f < 8; f++)
            runFrame($urandom_range(1, 6), $urandom_range(1, 4), 1'($urandom_range(0, 1)));

        // reset during PROC of block 1
        beginFrame(2, 3);
        loadBlock(2, 0, 0);
        procDrain(0, 3, 0);
        loadBlock(2, 1, 0);
        check("preResetIdx", o_blockIdx, 1);
        check("preResetPhase", o_phase, 2);
        d0 = doneCnt;
        i_reset = 1'b1;
        step();
        expErr = 1'b0;
        checkAll("midReset", 0, 0, 0, 0, 0, 0);
        i_reset = 1'b0;
        repeat (5) step();
        check("midResetNoDone", doneCnt - d0, 0);
        check("midResetIdle", o_phase, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end
endmodule
